// File: rtl/gate_response_checker.sv
// gate_response_checker
//   Watches the stimulus vector {A,B,C} driven into a delayed gate network and
//   the observed outputs {x,y}. Each time the stimulus changes it computes the
//   golden outputs x = (A&B)|~C, y = ~C, counts how many clock cycles the
//   observed outputs take to settle to them, and reports pass/fail, the settle
//   latency and timeouts.
//
// Ports
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   A, B, C        stimulus bits as driven to the gate network
//   x, y           observed gate network outputs
//   done           one-cycle pulse, result valid
//   pass           outputs settled to golden values (held until next done)
//   timeout        MAX_WAIT expired (held until next done)
//   settle_cycles  MEASURE-cycle index where the final matching run began
//   err_count      saturating count of failed measurements
//   glitch_cnt     match->mismatch transitions seen in the current/last window
//
// Build option
//   GLITCH_COUNT_EN  when defined, glitch_cnt counts re-breaking hazards;
//                    otherwise glitch_cnt is tied to zero.
//
// Handshake
//   There is no back-pressure: done is a single-cycle valid strobe, and pass,
//   timeout and settle_cycles change only in the cycle done is high.
//
// Debug
//   state_q holds the FSM state (IDLE/MEASURE/REPORT) for checkers to probe.

module gate_response_checker #(
  parameter int MAX_WAIT      = 15,
  parameter int STABLE_CYCLES = 3,
  parameter int CNT_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             A,
  input  logic             B,
  input  logic             C,
  input  logic             x,
  input  logic             y,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [CNT_W-1:0] settle_cycles,
  output logic [7:0]       err_count,
  output logic [7:0]       glitch_cnt
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_MEASURE = 2'd1;
  localparam logic [1:0] S_REPORT  = 2'd2;

  localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(MAX_WAIT - 1);
  localparam logic [CNT_W-1:0] MAX_VAL    = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] STABLE_TGT = CNT_W'(STABLE_CYCLES);

  // Input stage. These registers keep sampling during reset so that the
  // priming cycle right after reset sees the real stimulus, not zero.
  logic [2:0] abc_q;
  logic [1:0] xy_q;

  always_ff @(posedge clk) begin
    abc_q <= {A, B, C};
    xy_q  <= {x, y};
  end

  logic             primed_q, primed_d;
  logic [2:0]       abc_prev_q, abc_prev_d;
  logic [1:0]       state_q, state_d;
  logic [1:0]       exp_q, exp_d;
  logic [CNT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic [CNT_W-1:0] stable_cnt_q, stable_cnt_d;
  logic [CNT_W-1:0] start_idx_q, start_idx_d;
  logic             pass_q, pass_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] settle_q, settle_d;
  logic [7:0]       err_q, err_d;

  logic             chg;
  logic [1:0]       golden;
  logic             match;
  logic [CNT_W-1:0] stable_inc;
  logic             settled;
  logic [CNT_W-1:0] settle_idx;

  assign chg        = primed_q & (abc_q != abc_prev_q);
  assign golden     = {(abc_q[2] & abc_q[1]) | ~abc_q[0], ~abc_q[0]};
  assign match      = (xy_q == exp_q);
  assign stable_inc = stable_cnt_q + 1'b1;
  assign settled    = match & (stable_inc == STABLE_TGT);
  // When the run starts in the very cycle it completes (STABLE_CYCLES == 1)
  // start_idx_q has not been written yet, so take the live index.
  assign settle_idx = (stable_cnt_q == '0) ? lat_cnt_q : start_idx_q;

  always_comb begin
    primed_d     = 1'b1;
    abc_prev_d   = abc_q;
    state_d      = state_q;
    exp_d        = exp_q;
    lat_cnt_d    = lat_cnt_q;
    stable_cnt_d = stable_cnt_q;
    start_idx_d  = start_idx_q;
    pass_d       = pass_q;
    timeout_d    = timeout_q;
    settle_d     = settle_q;
    err_d        = err_q;

    if (chg) begin
      // A stimulus change always (re)starts a window, whatever the state;
      // an in-flight measurement is dropped without a report.
      state_d      = S_MEASURE;
      exp_d        = golden;
      lat_cnt_d    = '0;
      stable_cnt_d = '0;
    end else begin
      case (state_q)
        S_MEASURE: begin
          if (settled) begin
            state_d   = S_REPORT;
            pass_d    = 1'b1;
            timeout_d = 1'b0;
            settle_d  = settle_idx;
          end else if (lat_cnt_q == LAST_IDX) begin
            state_d   = S_REPORT;
            pass_d    = 1'b0;
            timeout_d = 1'b1;
            settle_d  = MAX_VAL;
            if (err_q != 8'hFF) err_d = err_q + 8'd1;
          end else begin
            lat_cnt_d    = lat_cnt_q + 1'b1;
            stable_cnt_d = match ? stable_inc : '0;
            if (match && (stable_cnt_q == '0)) start_idx_d = lat_cnt_q;
          end
        end
        S_REPORT: state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      primed_q     <= 1'b0;
      abc_prev_q   <= '0;
      state_q      <= S_IDLE;
      exp_q        <= '0;
      lat_cnt_q    <= '0;
      stable_cnt_q <= '0;
      start_idx_q  <= '0;
      pass_q       <= 1'b0;
      timeout_q    <= 1'b0;
      settle_q     <= '0;
      err_q        <= '0;
    end else begin
      primed_q     <= primed_d;
      abc_prev_q   <= abc_prev_d;
      state_q      <= state_d;
      exp_q        <= exp_d;
      lat_cnt_q    <= lat_cnt_d;
      stable_cnt_q <= stable_cnt_d;
      start_idx_q  <= start_idx_d;
      pass_q       <= pass_d;
      timeout_q    <= timeout_d;
      settle_q     <= settle_d;
      err_q        <= err_d;
    end
  end

  assign done          = (state_q == S_REPORT);
  assign pass          = pass_q;
  assign timeout       = timeout_q;
  assign settle_cycles = settle_q;
  assign err_count     = err_q;

`ifdef GLITCH_COUNT_EN
  // A glitch is a match followed by a mismatch inside one window.
  logic       prev_match_q, prev_match_d;
  logic [7:0] glitch_q, glitch_d;

  always_comb begin
    prev_match_d = prev_match_q;
    glitch_d     = glitch_q;
    if (chg) begin
      prev_match_d = 1'b0;
      glitch_d     = '0;
    end else if (state_q == S_MEASURE) begin
      prev_match_d = match;
      if (prev_match_q && !match && (glitch_q != 8'hFF)) glitch_d = glitch_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_match_q <= 1'b0;
      glitch_q     <= '0;
    end else begin
      prev_match_q <= prev_match_d;
      glitch_q     <= glitch_d;
    end
  end

  assign glitch_cnt = glitch_q;
`else
  assign glitch_cnt = 8'd0;
`endif

endmodule

// File: doc/gate_response_checker.md
Name: gate_response_checker

Overview:
- Synthesizable response-side companion to the gate-level stimulus benches: watches the stimulus vector {A,B,C} and the observed outputs {x,y} of the delayed gate network.
- On every stimulus change it computes the golden outputs x = (A&B)|~C and y = ~C.
- Measures how many clock cycles the observed outputs take to settle to those values, then reports pass/fail, settle latency and timeouts.
- Sits beside the device under test on hardware or in a synchronous bench, replacing manual waveform inspection.

Parameters:
- MAX_WAIT, 15: cycles allowed in MEASURE before timeout; 1..2^CNT_W-1.
- STABLE_CYCLES, 3: consecutive matching cycles required to declare settled; 1..MAX_WAIT.
- CNT_W, 4: width of the latency counter and of settle_cycles.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- A  input  1  stimulus bit A, as driven to the gate network.
- B  input  1  stimulus bit B.
- C  input  1  stimulus bit C.
- x  input  1  observed network output x.
- y  input  1  observed network output y.
- done  output  1  one-cycle pulse when a measurement result is valid.
- pass  output  1  result: outputs settled to golden values; valid with done, held until the next done.
- timeout  output  1  result: MAX_WAIT expired; valid with done, held until the next done.
- settle_cycles  output  CNT_W  MEASURE-cycle index at which the final matching run began; held until the next done.
- err_count  output  8  saturating count of failed measurements.
- glitch_cnt  output  8  glitch count; see Optional Feature.

Behaviour:
- Reset: one clock with rst=1 clears all state.
  - Outputs after reset: done=0, pass=0, timeout=0, settle_cycles=0, err_count=0, glitch_cnt=0.
  - State after reset: IDLE, primed=0.
- Input stage: A,B,C,x,y each pass through one register stage (abc_q, xy_q) before any use.
- Priming: the first cycle with primed=0 loads abc_prev<=abc_q, sets primed=1 and detects nothing. This prevents a false trigger on nonzero inputs right out of reset.
- Change detect: chg = primed & (abc_q != abc_prev). abc_prev<=abc_q every cycle once primed.
- FSM states: IDLE, MEASURE, REPORT.
- IDLE:
  - On chg: latch golden exp_x=(a&b)|~c and exp_y=~c from abc_q.
  - Clear lat_cnt and stable_cnt, then go to MEASURE.
- MEASURE (lat_cnt=0 on the first MEASURE cycle):
  - If xy_q=={exp_x,exp_y}: stable_cnt++. When stable_cnt goes 0->1, record start_idx<=lat_cnt.
  - On mismatch: stable_cnt<=0.
  - When stable_cnt reaches STABLE_CYCLES this cycle: go to REPORT with pass=1, timeout=0, settle_cycles=start_idx.
  - Otherwise, if lat_cnt==MAX_WAIT-1: go to REPORT with pass=0, timeout=1, settle_cycles=MAX_WAIT.
  - Otherwise: lat_cnt++.
  - Settling completes in the cycle it reaches STABLE_CYCLES and takes priority over timeout in the same cycle.
- Stimulus change in MEASURE (chg=1): abort silently, with no done and no count.
  - Relatch golden values from the new abc_q, clear lat_cnt, stable_cnt and glitch state, stay in MEASURE.
  - chg has priority over settle/timeout decisions in the same cycle.
- REPORT:
  - done=1 for exactly one cycle; pass, timeout and settle_cycles update in this cycle.
  - If pass=0: err_count++, saturating at 255.
  - Next state: IDLE. A chg seen during REPORT goes directly to MEASURE, so no change is lost.
- Latency: first possible done is the cycle after the STABLE_CYCLES-th matching MEASURE cycle.
- Reset mid-MEASURE: measurement discarded, no done, counters cleared, re-prime required.

Optional Feature:
- Macro: GLITCH_COUNT_EN.
- When defined: glitch_cnt counts match->mismatch transitions during MEASURE (a hazard that re-breaks after the outputs matched).
  - glitch_cnt is cleared on entry to MEASURE and saturates at 255.
  - It is held from REPORT until the next MEASURE entry.
- When undefined: glitch_cnt is tied to 0 and no glitch logic is synthesized. The port list is identical either way.

Test Plan:
- Reset with A,B,C=1,1,1, then hold inputs -> no done for 20 cycles; err_count=0.
- ABC 000->111; y=0 driven from MEASURE cycle 1, x=1 from cycle 4 -> done 1 cycle after cycle 6, pass=1, settle_cycles=4, timeout=0.
- ABC 111->000 with x stuck at 0 (golden x=1) -> done after 15 MEASURE cycles, pass=0, timeout=1, settle_cycles=15, err_count=1.
- ABC change, then a second change at MEASURE cycle 2, outputs correct from cycle 1 of the new window -> exactly one done, pass=1, settle_cycles=1.
- With GLITCH_COUNT_EN: outputs match at cycle 1, mismatch at cycle 2, match again from cycle 3 -> pass=1, settle_cycles=3, glitch_cnt=1. Without the macro -> glitch_cnt=0.
- 256 consecutive timeouts -> err_count saturates at 255; rst asserted in MEASURE -> no done, all outputs 0 the next cycle.
